keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad and encodes the pressed key into a 4-bit hex code for the seven-segment display path. The block drives one row at a time, synchronizes and debounces the column inputs, and emits exactly one strobe per debounced press. It is the input end of the keypad-to-display chain: `key`/`key_valid` feed the display register that shifts in new digits.

## Interface
- `DWELL_CYCLES`, default 12000: clock cycles each row is driven per scan step; must be ≥ 3.
- `DEBOUNCE_SCANS`, default 20: consecutive stable dwell periods required to accept a press or a release; must be ≥ 1.

Ports:
- `int_osc`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `col`  in  4: raw keypad columns, active-high when pressed, asynchronous to `int_osc`.
- `row`  out  4: one-hot, active-high row drive.
- `key`  out  4: hex code of the last accepted key.
- `key_valid`  out  1: one-cycle strobe when `key` is updated.
- `key_held`  out  1: high while the accepted key is still considered pressed.

## Operation
- `col` passes through a 2-flop synchronizer; all decisions use the synchronized value `scol`.
- Dwell counter runs 0..DWELL_CYCLES-1 and wraps. The "dwell end" is the cycle where count == DWELL_CYCLES-1. All FSM decisions are taken at the dwell end.
- Key map, row index r / column index c to code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- States:
  - SCAN:
    - `scol` == 0 or has more than one bit set: `row` rotates left (0001→0010→0100→1000→0001).
    - `scol` has exactly one bit set: capture r and c, clear `deb_cnt`, go to DEBOUNCE. `row` stays frozen.
  - DEBOUNCE (`row` frozen):
    - `scol` equals the captured one-hot column: `deb_cnt`+1.
    - Otherwise: go to SCAN and rotate `row`.
    - When `deb_cnt`+1 == DEBOUNCE_SCANS: load `key` with the code, pulse `key_valid`, go to HELD.
  - HELD (`row` frozen, `key_held`=1):
    - Captured column bit == 0: clear `deb_cnt`, go to RELEASE.
    - Extra columns set in `scol` are ignored.
  - RELEASE (`row` frozen, `key_held`=1):
    - Captured bit == 0: `deb_cnt`+1.
    - Captured bit == 1: return to HELD.
    - When `deb_cnt`+1 == DEBOUNCE_SCANS: go to SCAN and rotate `row`.
- `key` holds its value until the next accepted press. A release never changes `key`.
- Only one key is tracked at a time. Presses in other rows are invisible while `row` is frozen.
- `deb_cnt` is sized as clog2(DEBOUNCE_SCANS+1) bits and never wraps.

## Timing
- Reset values:
  - `row`=4'b0001, `key`=4'h0, `key_valid`=0, `key_held`=0.
  - State SCAN, dwell counter 0, `deb_cnt` 0, synchronizer flops 0.
- All outputs are registered. `key`, `key_valid` and `key_held` change on the same edge that enters HELD.
- `key_valid` is high for exactly one `int_osc` cycle per accepted press.
- `key_held` rises on the HELD-entry edge and falls on the edge that enters SCAN from RELEASE.
- Press latency: 2 synchronizer cycles, plus the remainder of the current row's dwell, plus DEBOUNCE_SCANS full dwells. Worst case with the wrong row active adds 3 more dwells.
- `row` changes only on dwell-end edges.
- Reset asserted mid-operation (any state) forces the reset values immediately, without waiting for a clock edge. After deassertion, scanning restarts at row 0001 with a fresh dwell count.

## Test plan
All scenarios use DWELL_CYCLES=4 and DEBOUNCE_SCANS=3. The bench models the keypad: it drives `col` bit c only while `row` bit r is high for each pressed key (r,c).
- Reset, no keys → `row` steps 0001,0010,0100,1000,0001, changing every 4 cycles; `key`=0, `key_valid`=0, `key_held`=0 throughout.
- Press (1,1) steadily → `key`=4'h5, `key_valid` high for 1 cycle, 3 dwells after the detection dwell; `row` frozen at 0010; `key_held`=1.
- Press (1,1), then drop `col` during the 2nd debounce dwell → no `key_valid`; `row` advances to 0100 and scanning resumes.
- Hold (3,3) for 20 dwells, then release → `key`=4'hD with exactly one `key_valid` pulse; `key_held` falls 3 dwells after release; `row` goes 1000→0001; `key` stays D.
- `col`=0011 during row 0001 (two keys in one row) → ignored, no strobe. Then release and press (0,3) alone → `key`=4'hA. While held, add (0,0) → no second strobe.
- Assert `reset` for 1 cycle while HELD on key 4'h9 → `key`=0, `key_held`=0, `row`=0001 before the next clock edge; after release of reset with the key still down, the block re-detects and strobes 4'h9 again.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot row drive, synchronized and debounced
// columns, one key_valid strobe per accepted press.
module keypad_scanner #(
  parameter int DWELL_CYCLES   = 12000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DW_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] DEB_N   = BW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    s1, scol;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb_cnt;
  logic [1:0]    cap_r;
  logic [3:0]    cap_c;

  function automatic logic [1:0] enc4(input logic [3:0] oh);
    enc4 = {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:  keymap = 4'h1;  4'd1:  keymap = 4'h2;  4'd2:  keymap = 4'h3;  4'd3:  keymap = 4'hA;
      4'd4:  keymap = 4'h4;  4'd5:  keymap = 4'h5;  4'd6:  keymap = 4'h6;  4'd7:  keymap = 4'hB;
      4'd8:  keymap = 4'h7;  4'd9:  keymap = 4'h8;  4'd10: keymap = 4'h9;  4'd11: keymap = 4'hC;
      4'd12: keymap = 4'hE;  4'd13: keymap = 4'h0;  4'd14: keymap = 4'hF;  default: keymap = 4'hD;
    endcase
  endfunction

  logic          dwell_end, one_hot, cap_hit;
  logic [BW-1:0] deb_nxt;
  logic [3:0]    row_rot;

  assign dwell_end = (dwell == DW_LAST);
  assign one_hot   = (scol != 4'b0) && ((scol & (scol - 4'd1)) == 4'b0);
  assign cap_hit   = |(scol & cap_c);
  assign deb_nxt   = deb_cnt + BW'(1);
  assign row_rot   = {row[2:0], row[3]};

  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      s1        <= '0;
      scol      <= '0;
      dwell     <= '0;
      deb_cnt   <= '0;
      cap_r     <= '0;
      cap_c     <= '0;
      row       <= 4'b0001;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      s1        <= col;
      scol      <= s1;
      key_valid <= 1'b0;
      dwell     <= dwell_end ? '0 : dwell + DW'(1);
      if (dwell_end) begin
        case (state)
          SCAN: begin
            // Zero or multiple columns in this row: keep scanning.
            if (one_hot) begin
              cap_r   <= enc4(row);
              cap_c   <= scol;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              row <= row_rot;
            end
          end
          DEBOUNCE: begin
            if (scol == cap_c) begin
              deb_cnt <= deb_nxt;
              if (deb_nxt == DEB_N) begin
                key       <= keymap(cap_r, enc4(cap_c));
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= HELD;
              end
            end else begin
              state <= SCAN;
              row   <= row_rot;
            end
          end
          HELD: begin
            // Only the captured column matters; extra columns are ignored.
            if (!cap_hit) begin
              deb_cnt <= '0;
              state   <= RELEASE;
            end
          end
          default: begin
            if (cap_hit) begin
              state <= HELD;
            end else begin
              deb_cnt <= deb_nxt;
              if (deb_nxt == DEB_N) begin
                key_held <= 1'b0;
                row      <= row_rot;
                state    <= SCAN;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model and a scoreboard of
// expected key codes popped on every key_valid strobe.
module tb_keypad_scanner;

  logic       int_osc = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] keys = '0;  // keys[r] = columns pressed in row r

  keypad_scanner #(.DWELL_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 int_osc = ~int_osc;

  always_comb begin
    col = 4'b0;
    for (int r = 0; r < 4; r++)
      if (row[r]) col = col | keys[r];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int stepno   = 0;
  int strobes  = 0;
  int last_strobe = -1;
  logic [3:0] sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0] e;
    @(negedge int_osc);
    stepno++;
    if (key_valid) begin
      strobes++;
      last_strobe = stepno;
      chk("sb_pending", (sbq.size() != 0) ? 1 : 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_key", key, e);
      end
    end
  endtask

  task automatic run_to(input int n);
    while (stepno < n) step();
  endtask

  task automatic wait_strobe(input int max);
    int s0 = strobes;
    int n = 0;
    while (strobes == s0 && n < max) begin
      step();
      n++;
    end
    chk("strobe_seen", (strobes != s0) ? 1 : 0, 1);
    step();
    chk("kv_one_cycle", key_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge int_osc);
    reset = 1'b1;
    #1;
    chk("rst_row", row, 4'b0001);
    chk("rst_key", key, 4'h0);
    chk("rst_kv", key_valid, 0);
    chk("rst_held", key_held, 0);
    @(negedge int_osc);
    reset = 1'b0;
    stepno = 0;
  endtask

  initial begin
    int s;
    // Idle scan: rows rotate every 4 cycles, outputs stay quiet.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("idle_row", row, 4'b0001 << ((k / 4) % 4));
    end
    chk("idle_key", key, 4'h0);
    chk("idle_held", key_held, 0);
    chk("idle_strobes", strobes, 0);

    // Steady press of (1,1): strobe at edge 20, row frozen.
    do_reset();
    keys[1] = 4'b0010;
    sbq.push_back(4'h5);
    wait_strobe(40);
    chk("p11_latency", last_strobe, 20);
    chk("p11_row", row, 4'b0010);
    chk("p11_held", key_held, 1);
    run_to(40);
    chk("p11_row_frozen", row, 4'b0010);
    chk("p11_one_strobe", strobes, 1);

    // Bounce: drop column during the 2nd debounce dwell.
    keys = '0;
    do_reset();
    s = strobes;
    keys[1] = 4'b0010;
    run_to(13);
    keys = '0;
    run_to(16);
    chk("bounce_row_a", row, 4'b0100);
    run_to(20);
    chk("bounce_row_b", row, 4'b1000);
    run_to(30);
    chk("bounce_no_strobe", strobes - s, 0);
    chk("bounce_held", key_held, 0);

    // Long hold of (3,3), then release.
    do_reset();
    s = strobes;
    keys[3] = 4'b1000;
    sbq.push_back(4'hD);
    wait_strobe(60);
    chk("p33_latency", last_strobe, 28);
    run_to(112);
    keys = '0;
    run_to(127);
    chk("rel_held_still", key_held, 1);
    chk("rel_row_frozen", row, 4'b1000);
    run_to(128);
    chk("rel_held_fall", key_held, 0);
    chk("rel_row_wrap", row, 4'b0001);
    chk("rel_key_kept", key, 4'hD);
    chk("rel_one_strobe", strobes - s, 1);

    // Two keys in one row are ignored; then (0,3) alone; then extra (0,0).
    do_reset();
    s = strobes;
    keys[0] = 4'b0011;
    run_to(40);
    chk("dual_no_strobe", strobes - s, 0);
    chk("dual_key", key, 4'h0);
    chk("dual_row", row, 4'b0100);
    keys[0] = 4'b1000;
    sbq.push_back(4'hA);
    wait_strobe(60);
    chk("p03_latency", last_strobe, 64);
    keys[0] = 4'b1001;
    s = strobes;
    run_to(stepno + 40);
    chk("extra_no_strobe", strobes - s, 0);
    chk("extra_held", key_held, 1);
    chk("extra_key", key, 4'hA);
    chk("extra_row", row, 4'b0001);

    // Reset pulse while HELD on 9; key stays down and is re-detected.
    keys = '0;
    do_reset();
    keys[2] = 4'b0100;
    sbq.push_back(4'h9);
    wait_strobe(60);
    chk("p22_latency", last_strobe, 24);
    run_to(30);
    reset = 1'b1;
    #1;
    chk("async_key", key, 4'h0);
    chk("async_held", key_held, 0);
    chk("async_row", row, 4'b0001);
    @(negedge int_osc);
    reset = 1'b0;
    stepno = 0;
    sbq.push_back(4'h9);
    wait_strobe(60);
    chk("redetect_latency", last_strobe, 24);
    chk("redetect_held", key_held, 1);
    chk("sb_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
